// File: rtl/axi_native_responder.sv
// AXI4 slave endpoint that turns each AW/W or AR burst into single-beat LiteDRAM
// native-port commands, one AXI transaction and one native command in flight.
module axi_native_responder #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256,
    parameter int ID_W   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  axi_aw_valid,
    output logic                  axi_aw_ready,
    input  logic [ADDR_W-1:0]     axi_aw_payload_addr,
    input  logic [1:0]            axi_aw_payload_burst,
    input  logic [7:0]            axi_aw_payload_len,
    input  logic [ID_W-1:0]       axi_aw_payload_id,
    input  logic                  axi_w_valid,
    output logic                  axi_w_ready,
    input  logic                  axi_w_last,
    input  logic [DATA_W-1:0]     axi_w_payload_data,
    input  logic [DATA_W/8-1:0]   axi_w_payload_strb,
    output logic                  axi_b_valid,
    input  logic                  axi_b_ready,
    output logic                  axi_b_first,
    output logic                  axi_b_last,
    output logic [1:0]            axi_b_payload_resp,
    output logic [ID_W-1:0]       axi_b_payload_id,
    input  logic                  axi_ar_valid,
    output logic                  axi_ar_ready,
    input  logic [ADDR_W-1:0]     axi_ar_payload_addr,
    input  logic [1:0]            axi_ar_payload_burst,
    input  logic [7:0]            axi_ar_payload_len,
    input  logic [ID_W-1:0]       axi_ar_payload_id,
    output logic                  axi_r_valid,
    input  logic                  axi_r_ready,
    output logic                  axi_r_first,
    output logic                  axi_r_last,
    output logic [DATA_W-1:0]     axi_r_payload_data,
    output logic [1:0]            axi_r_payload_resp,
    output logic [ID_W-1:0]       axi_r_payload_id,
    output logic                  native_cmd_valid,
    input  logic                  native_cmd_ready,
    output logic                  native_cmd_payload_we,
    output logic [31:0]           native_cmd_payload_addr,
    output logic                  wdata_valid,
    input  logic                  wdata_ready,
    output logic [DATA_W-1:0]     wdata_payload_data,
    output logic [DATA_W/8-1:0]   wdata_payload_we,
    input  logic                  rdata_valid,
    output logic                  rdata_ready,
    input  logic [DATA_W-1:0]     rdata_payload_data
);

    typedef enum logic [2:0] {
        IDLE, WR_CMD, WR_DATA, WR_RESP, RD_CMD, RD_DATA
    } state_t;

    state_t          state_q, state_d;
    logic [26:0]     base_q, base_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      beat_q, beat_d;
    logic [1:0]      burst_q, burst_d;
    logic [ID_W-1:0] id_q, id_d;
    logic            err_q, err_d;
    logic            last_grant_q, last_grant_d;

    logic            grant_wr, grant_rd, beat_last, w_hs, r_hs;
    logic [26:0]     word_addr;

    // Native word address is modulo 2^27, so INCR bursts past the top wrap to 0.
    always_comb begin
        grant_wr  = axi_aw_valid && (!axi_ar_valid || !last_grant_q);
        grant_rd  = axi_ar_valid && !grant_wr;
        beat_last = (beat_q == len_q);
        word_addr = (burst_q == 2'b01) ? base_q + 27'(beat_q) : base_q;
        w_hs      = axi_w_valid && (err_q || wdata_ready);
        r_hs      = axi_r_ready && (err_q || rdata_valid);
    end

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        len_d        = len_q;
        beat_d       = beat_q;
        burst_d      = burst_q;
        id_d         = id_q;
        err_d        = err_q;
        last_grant_d = last_grant_q;

        axi_aw_ready            = 1'b0;
        axi_ar_ready            = 1'b0;
        axi_w_ready             = 1'b0;
        axi_b_valid             = 1'b0;
        axi_b_first             = 1'b0;
        axi_b_last              = 1'b0;
        axi_b_payload_resp      = '0;
        axi_b_payload_id        = '0;
        axi_r_valid             = 1'b0;
        axi_r_first             = 1'b0;
        axi_r_last              = 1'b0;
        axi_r_payload_data      = '0;
        axi_r_payload_resp      = '0;
        axi_r_payload_id        = '0;
        native_cmd_valid        = 1'b0;
        native_cmd_payload_we   = 1'b0;
        native_cmd_payload_addr = '0;
        wdata_valid             = 1'b0;
        wdata_payload_data      = '0;
        wdata_payload_we        = '0;
        rdata_ready             = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_wr) begin
                    axi_aw_ready = 1'b1;
                    base_d       = 27'(axi_aw_payload_addr[ADDR_W-1:5]);
                    len_d        = axi_aw_payload_len;
                    burst_d      = axi_aw_payload_burst;
                    id_d         = axi_aw_payload_id;
                    beat_d       = '0;
                    err_d        = axi_aw_payload_burst[1];
                    last_grant_d = 1'b1;
                    state_d      = WR_CMD;
                end else if (grant_rd) begin
                    axi_ar_ready = 1'b1;
                    base_d       = 27'(axi_ar_payload_addr[ADDR_W-1:5]);
                    len_d        = axi_ar_payload_len;
                    burst_d      = axi_ar_payload_burst;
                    id_d         = axi_ar_payload_id;
                    beat_d       = '0;
                    err_d        = axi_ar_payload_burst[1];
                    last_grant_d = 1'b0;
                    state_d      = RD_CMD;
                end
            end
            WR_CMD: begin
                native_cmd_valid        = !err_q;
                native_cmd_payload_we   = 1'b1;
                native_cmd_payload_addr = 32'(word_addr);
                if (err_q || native_cmd_ready) state_d = WR_DATA;
            end
            WR_DATA: begin
                // Errored bursts still drain every W beat so the master is not stuck.
                if (err_q) begin
                    axi_w_ready = 1'b1;
                end else begin
                    wdata_valid        = axi_w_valid;
                    axi_w_ready        = wdata_ready;
                    wdata_payload_data = axi_w_payload_data;
                    wdata_payload_we   = axi_w_payload_strb;
                end
                if (w_hs) begin
                    if (axi_w_last != beat_last) err_d = 1'b1;
                    if (beat_last) begin
                        state_d = WR_RESP;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                        state_d = WR_CMD;
                    end
                end
            end
            WR_RESP: begin
                axi_b_valid        = 1'b1;
                axi_b_first        = 1'b1;
                axi_b_last         = 1'b1;
                axi_b_payload_resp = err_q ? 2'b10 : 2'b00;
                axi_b_payload_id   = id_q;
                if (axi_b_ready) state_d = IDLE;
            end
            RD_CMD: begin
                native_cmd_valid        = !err_q;
                native_cmd_payload_addr = 32'(word_addr);
                if (err_q || native_cmd_ready) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (err_q) begin
                    axi_r_valid = 1'b1;
                end else begin
                    axi_r_valid        = rdata_valid;
                    rdata_ready        = axi_r_ready;
                    axi_r_payload_data = rdata_payload_data;
                end
                axi_r_payload_resp = err_q ? 2'b10 : 2'b00;
                axi_r_payload_id   = id_q;
                axi_r_first        = (beat_q == 8'd0);
                axi_r_last         = beat_last;
                if (r_hs) begin
                    if (beat_last) begin
                        state_d = IDLE;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                        state_d = RD_CMD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            base_q       <= '0;
            len_q        <= '0;
            beat_q       <= '0;
            burst_q      <= '0;
            id_q         <= '0;
            err_q        <= 1'b0;
            last_grant_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            len_q        <= len_d;
            beat_q       <= beat_d;
            burst_q      <= burst_d;
            id_q         <= id_d;
            err_q        <= err_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule
